// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: MDUop values and FSM states.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle mult/div unit owning HI/LO. The result is computed at start and held
// in pend_hi/pend_lo until a down-counter releases it.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] MFALUa,
    input  logic [31:0] ALUb,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;

    mdu_op_e           op;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic signed [31:0] sa, sb;
    logic signed [31:0] q_s, r_s;
    logic [31:0]       q_u, r_u;

    assign op = mdu_op_e'(MDUop);
    assign sa = $signed(MFALUa);
    assign sb = $signed(ALUb);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
    always_comb begin
        prod_s = {{32{MFALUa[31]}}, MFALUa} * {{32{ALUb[31]}}, ALUb};
        prod_u = {32'b0, MFALUa} * {32'b0, ALUb};
    end

    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (ALUb != '0) begin
            q_u = MFALUa / ALUb;
            r_u = MFALUa % ALUb;
            if (MFALUa == 32'h8000_0000 && ALUb == '1) begin
                q_s = sa;
                r_s = '0;
            end else begin
                q_s = sa / sb;
                r_s = sa % sb;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_hi_d = (op == MDU_MULT) ? prod_s[63:32] : prod_u[63:32];
                            pend_lo_d = (op == MDU_MULT) ? prod_s[31:0]  : prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_hi_d = (op == MDU_DIV) ? r_s : r_u;
                            pend_lo_d = (op == MDU_DIV) ? q_s : q_u;
                            pend_wr_d = (ALUb != '0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = ST_DIV;
                        end
                        MDU_MTHI: hi_d = MFALUa;
                        MDU_MTLO: lo_d = MFALUa;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                // Divide-by-zero still runs the full latency but leaves HI/LO untouched.
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against a
// behavioural HI/LO model built from plain integer arithmetic.
module tb_mul_div_unit;

    localparam int unsigned MULT_K = 5;
    localparam int unsigned DIV_K  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  MDUop;
    logic [31:0] MFALUa;
    logic [31:0] ALUb;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mul_div_unit #(
        .MULT_CYCLES(MULT_K),
        .DIV_CYCLES (DIV_K)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .MDUop  (MDUop),
        .MFALUa (MFALUa),
        .ALUb   (ALUb),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op on HI/LO.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                pu = longint'(a) * longint'(b);
                exp_hi = pu[63:32];
                exp_lo = pu[31:0];
            end
            3'd3: begin
                if (sb != 0) begin
                    if (sa == 32'sh8000_0000 && sb == -1) begin
                        exp_lo = 32'h8000_0000;
                        exp_hi = 32'h0;
                    end else begin
                        exp_lo = sa / sb;
                        exp_hi = sa % sb;
                    end
                end
            end
            3'd4: begin
                if (b != 0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op; optionally inject a second start at busy-cycle inj_i, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_i, input logic [2:0] inj_op);
        int unsigned k;
        logic [31:0] old_hi, old_lo;
        k = (op == 3'd1 || op == 3'd2) ? MULT_K : (op == 3'd3 || op == 3'd4) ? DIV_K : 0;
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        start = 1'b1; MDUop = op; MFALUa = a; ALUb = b;
        @(negedge clk);
        start = 1'b0; MDUop = 3'd0;
        model_apply(op, a, b);
        for (int i = 0; i < int'(k); i++) begin
            chk({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
            chk({tag, "_hold_HI"}, HI, old_hi);
            chk({tag, "_hold_LO"}, LO, old_lo);
            if (i == inj_i) begin
                start = 1'b1; MDUop = inj_op; MFALUa = $urandom; ALUb = $urandom;
            end else begin
                start = 1'b0; MDUop = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; MDUop = 3'd0;
        chk({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
        chk({tag, "_HI"}, HI, exp_hi);
        chk({tag, "_LO"}, LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        total = 0;
        bad = 0;
        exp_hi = '0;
        exp_lo = '0;
        reset_n = 1'b0;
        start = 1'b0;
        MDUop = 3'd0;
        MFALUa = '0;
        ALUb = '0;

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        reset_n = 1'b1;

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, -1, 3'd0);
        chk("mult_neg_HI_const", HI, 32'hFFFF_FFFF);
        chk("mult_neg_LO_const", LO, 32'hFFFF_FFFA);

        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0);
        chk("multu_HI_const", HI, 32'hFFFF_FFFE);
        chk("multu_LO_const", LO, 32'h0000_0001);

        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, -1, 3'd0);
        chk("div_neg_LO_const", LO, 32'hFFFF_FFFD);
        chk("div_neg_HI_const", HI, 32'hFFFF_FFFF);

        run_op("divu_7_2", 3'd4, 32'd7, 32'd2, -1, 3'd0);
        chk("divu_LO_const", LO, 32'd3);
        chk("divu_HI_const", HI, 32'd1);

        run_op("mthi", 3'd5, 32'h11, 32'h0, -1, 3'd0);
        run_op("mtlo", 3'd6, 32'h22, 32'h0, -1, 3'd0);
        run_op("div_zero", 3'd3, 32'h1234_5678, 32'h0, -1, 3'd0);
        chk("div_zero_HI_const", HI, 32'h11);
        chk("div_zero_LO_const", LO, 32'h22);
        run_op("divu_zero", 3'd4, 32'hDEAD_BEEF, 32'h0, -1, 3'd0);

        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0);
        chk("div_ovf_LO_const", LO, 32'h8000_0000);
        chk("div_ovf_HI_const", HI, 32'h0);

        run_op("op_none", 3'd0, 32'hAAAA_5555, 32'h1, -1, 3'd0);
        run_op("op_rsvd", 3'd7, 32'hAAAA_5555, 32'h1, -1, 3'd0);

        run_op("div_inj_mult", 3'd3, 32'd100, 32'hFFFF_FFF9, 2, 3'd1);
        run_op("div_inj_mthi", 3'd3, 32'd12345, 32'd7, 4, 3'd5);
        run_op("mult_inj_last", 3'd1, 32'd9, 32'd9, int'(MULT_K) - 1, 3'd6);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h8000_0000; rb = '1; end
                default: ;
            endcase
            run_op("rand", rop, ra, rb, ($urandom_range(0, 3) == 0) ? 1 : -1,
                   3'($urandom_range(1, 6)));
        end

        // Asynchronous reset in the middle of a mult discards it.
        run_op("pre_rst_mthi", 3'd5, 32'h5A5A_0001, 32'h0, -1, 3'd0);
        @(negedge clk);
        start = 1'b1; MDUop = 3'd1; MFALUa = 32'd1000; ALUb = 32'd1000;
        @(negedge clk);
        start = 1'b0; MDUop = 3'd0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_HI", HI, 32'd0);
        chk("rst_mid_LO", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < int'(MULT_K) + 3; i++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'b0, busy}, 32'd0);
            chk("post_rst_HI", HI, 32'd0);
            chk("post_rst_LO", LO, 32'd0);
        end

        run_op("post_rst_multu", 3'd2, 32'h0001_0000, 32'h0001_0000, -1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
